// File: rtl/caf_pkg.sv
// Shared definitions for the window builder: fill-count width helper and the
// window state encoding.
package caf_pkg;

  typedef enum logic [0:0] {
    ST_FILL   = 1'b0,
    ST_STREAM = 1'b1
  } win_state_e;

  // Bits needed to hold a fill count from 0 up to and including n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cpx_shift_reg.sv
// Enable-gated complex shift register: slot 0 is the oldest sample and slot
// length-1 the newest. Both windows are exposed as packed vectors.
module cpx_shift_reg
  import caf_pkg::*;
#(
  parameter int i_bits = 12,
  parameter int q_bits = 12,
  parameter int length = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic signed [i_bits-1:0]   xi,
  input  logic signed [q_bits-1:0]   xq,
  output logic [i_bits*length-1:0]   xi_win,
  output logic [q_bits*length-1:0]   xq_win
);

  logic signed [i_bits-1:0] si_q [length];
  logic signed [i_bits-1:0] si_d [length];
  logic signed [q_bits-1:0] sq_q [length];
  logic signed [q_bits-1:0] sq_d [length];

  always_comb begin
    for (int k = 0; k < length; k++) begin
      si_d[k] = si_q[k];
      sq_d[k] = sq_q[k];
    end
    if (en) begin
      for (int k = 0; k < length - 1; k++) begin
        si_d[k] = si_q[k + 1];
        sq_d[k] = sq_q[k + 1];
      end
      si_d[length - 1] = xi;
      sq_d[length - 1] = xq;
    end
  end

  // ---- slot registers ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < length; k++) begin
        si_q[k] <= '0;
        sq_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < length; k++) begin
        si_q[k] <= si_d[k];
        sq_q[k] <= sq_d[k];
      end
    end
  end

  for (genvar k = 0; k < length; k++) begin : g_pack
    assign xi_win[i_bits*k +: i_bits] = si_q[k];
    assign xq_win[q_bits*k +: q_bits] = sq_q[k];
  end

endmodule

// File: rtl/sample_window.sv
// Serial-to-parallel complex window builder (sliding, stride 1). Defining
// SAMPLE_WINDOW_BLOCK_EN switches to non-overlapping windows of `length` samples.
module sample_window
  import caf_pkg::*;
#(
  parameter int i_bits = 12,
  parameter int q_bits = 12,
  parameter int length = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       m_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic signed [i_bits-1:0]   xi,
  input  logic signed [q_bits-1:0]   xq,
  input  logic                       m_axis_window_tready,
  output logic                       s_axis_window_tvalid,
  output logic [i_bits*length-1:0]   xi_win,
  output logic [q_bits*length-1:0]   xq_win
);

  localparam int CW = cnt_w(length);
  localparam logic [CW-1:0] LAST_FILL = CW'(length - 1);
  localparam logic [CW-1:0] FULL      = CW'(length);

  win_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tvalid_q, tvalid_d;
  logic          accept;
  logic          xfer;

  // A stalled window blocks intake so its slots cannot move under it.
  assign s_axis_tready        = rst_n & (~tvalid_q | m_axis_window_tready);
  assign accept               = m_axis_tvalid & s_axis_tready;
  assign xfer                 = tvalid_q & m_axis_window_tready;
  assign s_axis_window_tvalid = tvalid_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tvalid_d = tvalid_q;
    if (xfer) tvalid_d = 1'b0;
    if (accept) begin
      case (state_q)
        ST_FILL: begin
          if (cnt_q == LAST_FILL) begin
            tvalid_d = 1'b1;
`ifdef SAMPLE_WINDOW_BLOCK_EN
            cnt_d    = '0;
`else
            cnt_d    = FULL;
            state_d  = ST_STREAM;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_STREAM: tvalid_d = 1'b1;
        default:   state_d  = ST_FILL;
      endcase
    end
  end

  // ---- control registers ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_FILL;
      cnt_q    <= '0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tvalid_q <= tvalid_d;
    end
  end

  cpx_shift_reg #(
    .i_bits(i_bits),
    .q_bits(q_bits),
    .length(length)
  ) u_shift (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (accept),
    .xi     (xi),
    .xq     (xq),
    .xi_win (xi_win),
    .xq_win (xq_win)
  );

endmodule

// File: tb/tb_sample_window.sv
// Directed bench for sample_window: a queue-based history model checked every
// cycle, plus hand-computed window literals. Honours SAMPLE_WINDOW_BLOCK_EN.
module tb_sample_window;

  localparam int L = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_tv;
  logic        s_tr;
  logic [11:0] xi, xq;
  logic        m_wr;
  logic        s_wv;
  logic [59:0] xi_win, xq_win;

  always #5 clk = ~clk;

  sample_window #(.i_bits(12), .q_bits(12), .length(L)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .m_axis_tvalid        (m_tv),
    .s_axis_tready        (s_tr),
    .xi                   (xi),
    .xq                   (xq),
    .m_axis_window_tready (m_wr),
    .s_axis_window_tvalid (s_wv),
    .xi_win               (xi_win),
    .xq_win               (xq_win)
  );

  int total = 0;
  int bad   = 0;
  bit run   = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: remember the last L accepted samples; window = those, zero padded.
  logic [11:0] hi[$];
  logic [11:0] hq[$];
  int          blk_n = 0;
  bit          exp_v = 1'b0;
  bit          m_acc, m_xfer;
  logic [59:0] wins[$];

  function automatic logic [59:0] pack(input logic [11:0] h[$]);
    logic [59:0] w;
    int          idx;
    w = '0;
    for (int k = 0; k < L; k++) begin
      idx = h.size() - L + k;
      if (idx >= 0) w[12*k +: 12] = h[idx];
    end
    return w;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      hi.delete();
      hq.delete();
      blk_n = 0;
      exp_v = 1'b0;
    end else begin
      m_acc  = m_tv && (!exp_v || m_wr);
      m_xfer = exp_v && m_wr;
      if (m_xfer) exp_v = 1'b0;
      if (m_acc) begin
        hi.push_back(xi);
        hq.push_back(xq);
        if (hi.size() > L) begin
          void'(hi.pop_front());
          void'(hq.pop_front());
        end
`ifdef SAMPLE_WINDOW_BLOCK_EN
        blk_n++;
        if (blk_n == L) begin
          exp_v = 1'b1;
          blk_n = 0;
        end
`else
        if (hi.size() == L) exp_v = 1'b1;
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("s_axis_tready", {63'd0, s_tr}, {63'd0, rst_n && (!exp_v || m_wr)});
      chk("tvalid", {63'd0, s_wv}, {63'd0, exp_v});
      chk("xi_win", {4'd0, xi_win}, {4'd0, pack(hi)});
      chk("xq_win", {4'd0, xq_win}, {4'd0, pack(hq)});
      if (s_wv && m_wr) wins.push_back(xi_win);
    end
  end

  task automatic cyc(input bit rn, input bit v, input logic [11:0] i,
                     input logic [11:0] q, input bit wr);
    rst_n = rn; m_tv = v; xi = i; xq = q; m_wr = wr;
    @(posedge clk);
    #2;
  endtask

  localparam logic [59:0] WI_1_5  = {12'd5, 12'd4, 12'd3, 12'd2, 12'd1};
  localparam logic [59:0] WQ_1_5  = {12'hFFB, 12'hFFC, 12'hFFD, 12'hFFE, 12'hFFF};
  localparam logic [59:0] WI_2_6  = {12'd6, 12'd5, 12'd4, 12'd3, 12'd2};
  localparam logic [59:0] WI_3_7  = {12'd7, 12'd6, 12'd5, 12'd4, 12'd3};
  localparam logic [59:0] WQ_3_7  = {12'hFF9, 12'hFFA, 12'hFFB, 12'hFFC, 12'hFFD};
  localparam logic [59:0] WI_4_8  = {12'd8, 12'd7, 12'd6, 12'd5, 12'd4};
  localparam logic [59:0] WI_6_10 = {12'd10, 12'd9, 12'd8, 12'd7, 12'd6};
  localparam logic [59:0] W_MIN   = {5{12'h800}};
  localparam logic [59:0] W_MAX   = {5{12'h7FF}};

  initial begin
    // Test 1: reset mid-fill, then a full refill
    cyc(0, 1, 12'd0, 12'd0, 1);
    cyc(0, 1, 12'd0, 12'd0, 1);
    for (int k = 0; k < 3; k++) cyc(1, 1, 12'(100 + k), 12'(200 + k), 1);
    cyc(0, 1, 12'd0, 12'd0, 1);
    chk("t1_rst_tvalid", {63'd0, s_wv}, 64'd0);
    chk("t1_rst_xi", {4'd0, xi_win}, 64'd0);
    for (int k = 0; k < 5; k++) begin
      cyc(1, 1, 12'(20 + k), 12'(40 + k), 1);
      chk("t1_fill_tvalid", {63'd0, s_wv}, (k == 4) ? 64'd1 : 64'd0);
    end

    // Test 2: fill 1..5 / -1..-5
    cyc(0, 0, 12'd0, 12'd0, 1);
    for (int k = 1; k <= 5; k++) begin
      cyc(1, 1, 12'(k), 12'(-k), 1);
      chk("t2_tvalid", {63'd0, s_wv}, (k == 5) ? 64'd1 : 64'd0);
    end
    chk("t2_xi", {4'd0, xi_win}, {4'd0, WI_1_5});
    chk("t2_xq", {4'd0, xq_win}, {4'd0, WQ_1_5});

`ifndef SAMPLE_WINDOW_BLOCK_EN
    // Test 3: streaming 6, 7
    cyc(1, 1, 12'd6, 12'(-6), 1);
    chk("t3_xi_a", {4'd0, xi_win}, {4'd0, WI_2_6});
    chk("t3_tvalid_a", {63'd0, s_wv}, 64'd1);
    cyc(1, 1, 12'd7, 12'(-7), 1);
    chk("t3_xi_b", {4'd0, xi_win}, {4'd0, WI_3_7});
    chk("t3_xq_b", {4'd0, xq_win}, {4'd0, WQ_3_7});
    chk("t3_tvalid_b", {63'd0, s_wv}, 64'd1);

    // Test 4: stall with a sample pending, then resume
    for (int k = 0; k < 4; k++) begin
      cyc(1, 1, 12'd8, 12'(-8), 0);
      chk("t4_stall_xi", {4'd0, xi_win}, {4'd0, WI_3_7});
      chk("t4_stall_tvalid", {63'd0, s_wv}, 64'd1);
    end
    cyc(1, 1, 12'd8, 12'(-8), 1);
    chk("t4_resume_xi", {4'd0, xi_win}, {4'd0, WI_4_8});
    chk("t4_resume_tvalid", {63'd0, s_wv}, 64'd1);
    cyc(1, 0, 12'd0, 12'd0, 1);
    chk("t4_drain_tvalid", {63'd0, s_wv}, 64'd0);
    chk("t4_drain_xi", {4'd0, xi_win}, {4'd0, WI_4_8});

    // Test 5: extreme values through every slot
    for (int k = 0; k < 5; k++) cyc(1, 1, 12'h800, 12'h7FF, 1);
    chk("t5_xi", {4'd0, xi_win}, {4'd0, W_MIN});
    chk("t5_xq", {4'd0, xq_win}, {4'd0, W_MAX});
    cyc(1, 0, 12'd0, 12'd0, 1);
`else
    // Test 6: non-overlapping windows 1..5 and 6..10
    cyc(0, 0, 12'd0, 12'd0, 1);
    wins.delete();
    for (int k = 1; k <= 10; k++) begin
      cyc(1, 1, 12'(k), 12'(-k), 1);
      chk("t6_tvalid", {63'd0, s_wv}, (k == 5 || k == 10) ? 64'd1 : 64'd0);
    end
    cyc(1, 0, 12'd0, 12'd0, 1);
    chk("t6_win_count", 64'(wins.size()), 64'd2);
    chk("t6_win0", {4'd0, (wins.size() > 0) ? wins[0] : 60'd0}, {4'd0, WI_1_5});
    chk("t6_win1", {4'd0, (wins.size() > 1) ? wins[1] : 60'd0}, {4'd0, WI_6_10});
    chk("t6_after_tvalid", {63'd0, s_wv}, 64'd0);
`endif

    cyc(1, 0, 12'd0, 12'd0, 1);
    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
